// File: rtl/inst_mem_resp_if.sv
// Fetch/loader bus of the instruction-memory responder.
// The master side is the fetch stage plus the loader; the slave side is inst_mem_resp.
interface inst_mem_resp_if;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic        addr_err;
    logic        mem_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_drop;

    modport master (
        output inst_addr, wr_en, wr_addr, wr_data,
        input  inst, addr_err, mem_ready, wr_drop
    );

    modport slave (
        input  inst_addr, wr_en, wr_addr, wr_data,
        output inst, addr_err, mem_ready, wr_drop
    );
endinterface

// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: one-clock synchronous read for the fetch stage, loader write port.
// Optional build macro INST_MEM_CLEAR_EN adds a zeroing sweep of the array after reset.
module inst_mem_resp #(
    parameter logic [31:0] BASE_ADDR = 32'hbfc00000,
    parameter int          DEPTH     = 1024
) (
    input  logic            clk,
    input  logic            resetn,
    inst_mem_resp_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);

`ifdef INST_MEM_CLEAR_EN
    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
    localparam state_t ST_INIT = ST_CLEAR;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
`else
    typedef enum logic {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_t;
    localparam state_t ST_INIT = ST_BOOT;
`endif

    state_t             state_r;
    logic [31:0]        mem_r [DEPTH];
    logic [31:0]        inst_r;
    logic               addr_err_r;
    logic               mem_ready_r;
    logic               wr_drop_r;
`ifdef INST_MEM_CLEAR_EN
    logic [ADDR_W-1:0]  cnt_r;
`endif

    logic [ADDR_W-1:0]  rd_idx_s;
    logic [ADDR_W-1:0]  wr_idx_s;
    logic               rd_hit_s;
    logic               wr_hit_s;
    logic [31:0]        rd_word_s;
    logic               mem_we_s;
    logic [ADDR_W-1:0]  mem_waddr_s;
    logic [31:0]        mem_wdata_s;
    logic               wr_drop_s;

    // A byte address hits when its upper bits select this window and it is word aligned.
    function automatic logic win_hit(input logic [31:0] addr);
        return (addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]) && (addr[1:0] == 2'b00);
    endfunction

    assign rd_hit_s  = win_hit(bus.inst_addr);
    assign wr_hit_s  = win_hit(bus.wr_addr);
    assign rd_idx_s  = bus.inst_addr[ADDR_W+1:2];
    assign wr_idx_s  = bus.wr_addr[ADDR_W+1:2];
    // Old contents are read here; the write below lands after the edge, giving read-first.
    assign rd_word_s = mem_r[rd_idx_s];

    // Select what the single array write port does this cycle and whether a loader write is lost.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_idx_s;
        mem_wdata_s = bus.wr_data;
        wr_drop_s   = 1'b0;
        if (state_r == ST_RUN) begin
            mem_we_s  = resetn && bus.wr_en && wr_hit_s;
            wr_drop_s = bus.wr_en && !wr_hit_s;
        end else begin
            wr_drop_s = bus.wr_en;
`ifdef INST_MEM_CLEAR_EN
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_r;
            mem_wdata_s = 32'h0000_0000;
`else
            mem_we_s    = 1'b0;
`endif
        end
    end

    // Storage array; never reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Control FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= ST_INIT;
            inst_r      <= 32'h0000_0000;
            addr_err_r  <= 1'b0;
            mem_ready_r <= 1'b0;
            wr_drop_r   <= 1'b0;
`ifdef INST_MEM_CLEAR_EN
            cnt_r       <= '0;
`endif
        end else begin
            wr_drop_r <= wr_drop_s;
            case (state_r)
`ifdef INST_MEM_CLEAR_EN
                ST_CLEAR: begin
                    inst_r     <= 32'h0000_0000;
                    addr_err_r <= 1'b0;
                    // Terminal compare before increment keeps cnt inside the array.
                    if (cnt_r == LAST_IDX) begin
                        state_r     <= ST_RUN;
                        mem_ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + ADDR_W'(1);
                    end
                end
`else
                ST_BOOT: begin
                    inst_r      <= 32'h0000_0000;
                    addr_err_r  <= 1'b0;
                    state_r     <= ST_RUN;
                    mem_ready_r <= 1'b1;
                end
`endif
                ST_RUN: begin
                    inst_r      <= rd_hit_s ? rd_word_s : 32'h0000_0000;
                    addr_err_r  <= !rd_hit_s;
                    mem_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_INIT;
                    inst_r      <= 32'h0000_0000;
                    addr_err_r  <= 1'b0;
                    mem_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inst      = inst_r;
    assign bus.addr_err  = addr_err_r;
    assign bus.mem_ready = mem_ready_r;
    assign bus.wr_drop   = wr_drop_r;
endmodule

// File: tb/tb_inst_mem_resp.sv
// Scoreboard bench for inst_mem_resp (DEPTH=16): stimulus pushes expectations, a monitor pops and checks.
module tb_inst_mem_resp;
    localparam logic [31:0] B     = 32'hbfc00000;
    localparam int          DEPTH = 16;
`ifdef INST_MEM_CLEAR_EN
    localparam int          READY_EDGES = DEPTH;
    localparam logic [31:0] W0_AFTER_RESET = 32'h0000_0000;
`else
    localparam int          READY_EDGES = 1;
    localparam logic [31:0] W0_AFTER_RESET = 32'h2408_0001;
`endif

    logic clk = 1'b0;
    logic resetn;
    inst_mem_resp_if bus();

    inst_mem_resp #(.BASE_ADDR(B), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic        drop;
        logic        ready;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   k = 0;

    task automatic chk1(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Expectations in sb_q are written for RUN; before RUN the bench expects
    // zero output and every presented write dropped.
    task automatic step(input logic rst, input logic [31:0] addr, input logic we,
                        input logic [31:0] wa, input logic [31:0] wd,
                        input logic [31:0] ei, input logic ee, input logic ed,
                        input string nm);
        exp_t e;
        logic in_run;
        @(negedge clk);
        resetn        = rst;
        bus.inst_addr = addr;
        bus.wr_en     = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        in_run = rst && (k >= READY_EDGES);
        k      = rst ? k + 1 : 0;
        e.inst  = in_run ? ei : 32'h0000_0000;
        e.err   = in_run ? ee : 1'b0;
        e.drop  = rst ? (in_run ? ed : we) : 1'b0;
        e.ready = rst && (k >= READY_EDGES);
        e.name  = nm;
        sb_q.push_back(e);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] ei, input logic ee, input string nm);
        step(1'b1, addr, 1'b0, 32'h0, 32'h0, ei, ee, 1'b0, nm);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [31:0] ei, input logic ee, input logic ed, input string nm);
        step(1'b1, addr, 1'b1, wa, wd, ei, ee, ed, nm);
    endtask

    // Monitor: one expectation per clock edge, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk1({e.name, " inst"}, bus.inst, e.inst);
                chk1({e.name, " addr_err"}, {31'b0, bus.addr_err}, {31'b0, e.err});
                chk1({e.name, " wr_drop"}, {31'b0, bus.wr_drop}, {31'b0, e.drop});
                chk1({e.name, " mem_ready"}, {31'b0, bus.mem_ready}, {31'b0, e.ready});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        resetn        = 1'b0;
        bus.inst_addr = 32'h0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = 32'h0;
        bus.wr_data   = 32'h0;

        step(1'b0, B, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, "reset0");
        step(1'b0, B, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, "reset1");

        // Initial sweep with a loader write on its first edge and out-of-window reads mixed in.
        for (int i = 1; i <= READY_EDGES; i++) begin
            a = (i % 2 == 1) ? 32'h0000_0000 : B + 32'h3c;
            step(1'b1, a, (i == 1), B + 32'h4, 32'h1111_1111, 32'h0, 1'b0, 1'b0, "sweep");
        end

`ifndef INST_MEM_CLEAR_EN
        wr(32'h0, B + 32'h04, 32'h0, 32'h0, 1'b1, 1'b0, "prewrite1");
        wr(32'h0, B + 32'h3c, 32'h0, 32'h0, 1'b1, 1'b0, "prewrite15");
`endif
        rd(B + 32'h3c, 32'h0, 1'b0, "read_last_cleared");
        wr(B + 32'h3c, B, 32'h2408_0001, 32'h0, 1'b0, 1'b0, "load_w0");
        rd(B, 32'h2408_0001, 1'b0, "read_w0");
        wr(B + 32'h04, B + 32'h04, 32'hdead_beef, 32'h0, 1'b0, 1'b0, "same_edge_old");
        rd(B + 32'h04, 32'hdead_beef, 1'b0, "same_edge_new");
        rd(32'h0000_0000, 32'h0, 1'b1, "oow_zero");
        rd(B + 32'h02, 32'h0, 1'b1, "misaligned");
        rd(B, 32'h2408_0001, 1'b0, "err_clear");
        rd(B + 32'h40, 32'h0, 1'b1, "past_window");

        wr(B, 32'h8000_0000, 32'hcafe_f00d, 32'h2408_0001, 1'b0, 1'b1, "drop_oow");
        wr(B, B + 32'h06, 32'h5555_5555, 32'h2408_0001, 1'b0, 1'b1, "drop_misaligned");
        wr(B + 32'h04, B + 32'h40, 32'h7777_7777, 32'hdead_beef, 1'b0, 1'b1, "drop_past_window");
        rd(B + 32'h04, 32'hdead_beef, 1'b0, "drop_released");
        rd(B, 32'h2408_0001, 1'b0, "w0_unchanged");
        wr(B + 32'h3c, B + 32'h3c, 32'h0bad_f00d, 32'h0, 1'b0, 1'b0, "load_last");
        rd(B + 32'h3c, 32'h0bad_f00d, 1'b0, "read_last");

        // Reset, run 7 edges (cnt reaches 7 in the sweep build), reset again, full restart.
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, "reset_again");
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, "sweep_a");
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, "reset_mid_sweep");
        for (int i = 0; i < READY_EDGES; i++) begin
            step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, "sweep_b");
        end
        rd(B, W0_AFTER_RESET, 1'b0, "after_resweep");

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
